spi_master: RTL and testbench

Single-clock SPI bus master for one byte per transfer, full duplex, with four active-low slave selects and run-time selection of SPI mode 0–3. It sits between the on-chip logic (byte-wide parallel interface with start and done strobes) and external SPI slaves. The SPI clock is derived from the system clock by an integer divider. The matching slave blocks (mode 0 and mode 3) are separate blocks.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_clk_gen.sv | 43 ++++
 rtl/spi_master.sv | 106 ++++++++++
 tb/tb_spi_master.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master block.
package spi_pkg;
  localparam int DATA_W   = 8;
  localparam int N_SLAVES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } state_t;

  // Field order matches the SPI_MODE port: {CPOL, CPHA}.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;
endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: s_clk toggles every HP cycles while enabled, idles at cpol otherwise.
// lead/trail strobe in the cycle before the corresponding s_clk transition.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic cpol,
  output logic s_clk,
  output logic lead,
  output logic trail
);
  localparam int HP = CLK_DIV / 2;
  localparam int CW = (HP > 1) ? $clog2(HP) : 1;

  logic [CW-1:0] cnt;
  logic          ph;
  logic          tick;

  // First tick lands in the first enabled cycle, then every HP cycles.
  assign tick  = en && (cnt == '0);
  assign lead  = tick && !ph;
  assign trail = tick && ph;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      ph    <= 1'b0;
      s_clk <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      ph    <= 1'b0;
      s_clk <= cpol;
    end else begin
      cnt <= (cnt == CW'(HP - 1)) ? '0 : cnt + 1'b1;
      if (tick) begin
        ph    <= ~ph;
        s_clk <= ~s_clk;
      end
    end
  end
endmodule

// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master, modes 0-3, four active-low selects.
// Build option: define SPI_LSB_FIRST_EN to shift LSB first on mosi and miso.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              P_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  output logic [DATA_W-1:0] rx_data,
  input  logic [1:0]        ss,
  output logic              s0,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s_clk,
  output logic              mosi,
  input  logic              miso,
  input  logic              i_mode_set,
  input  logic [1:0]        SPI_MODE,
  output logic              spic
);
  localparam int HP = CLK_DIV / 2;
  localparam int TW = $clog2(16 * HP);

  state_t              state, state_nx;
  mode_t               mode;
  logic [1:0]          ss_q;
  logic [DATA_W-1:0]   sreg, sreg_in;
  logic [TW-1:0]       tcnt;
  logic [N_SLAVES-1:0] sel_n;
  logic                lead, trail, sample_ev, shift_ev, out_bit, busy;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk   (P_clk),
    .reset (reset),
    .en    (state == ST_XFER),
    .cpol  (mode.cpol),
    .s_clk (s_clk),
    .lead  (lead),
    .trail (trail)
  );

  assign sample_ev = mode.cpha ? trail : lead;
  assign shift_ev  = mode.cpha ? lead : trail;
  assign busy      = (state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD);
  assign {s3, s2, s1, s0} = sel_n;

`ifdef SPI_LSB_FIRST_EN
  assign out_bit = sreg[0];
  assign sreg_in = {miso, sreg[DATA_W-1:1]};
`else
  assign out_bit = sreg[DATA_W-1];
  assign sreg_in = {sreg[DATA_W-2:0], miso};
`endif

  always_ff @(posedge P_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (tx_start)                     state_nx = ST_SETUP;
      ST_SETUP: if (tcnt == TW'(HP - 1))          state_nx = ST_XFER;
      ST_XFER:  if (tcnt == TW'(16 * HP - 1))     state_nx = ST_HOLD;
      ST_HOLD:  if (tcnt == TW'(HP - 1))          state_nx = ST_DONE;
      ST_DONE:                                    state_nx = ST_IDLE;
      default:                                    state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so every pin lags the state by one cycle.
  always_ff @(posedge P_clk) begin
    if (reset) begin
      tcnt    <= '0;
      mode    <= '0;
      ss_q    <= '0;
      sreg    <= '0;
      mosi    <= 1'b0;
      rx_data <= '0;
      spic    <= 1'b0;
      sel_n   <= '1;
    end else begin
      tcnt  <= (state_nx != state || state == ST_IDLE) ? '0 : tcnt + 1'b1;
      spic  <= (state == ST_DONE);
      sel_n <= busy ? ~(N_SLAVES'(1) << ss_q) : '1;
      if (state == ST_IDLE) begin
        if (i_mode_set) mode <= mode_t'(SPI_MODE);
        if (tx_start) begin
          sreg <= tx_data;
          ss_q <= ss;
        end
      end
      if ((state == ST_SETUP && !mode.cpha) || shift_ev) mosi <= out_bit;
      if (sample_ev) sreg <= sreg_in;
      if (state == ST_DONE) begin
        rx_data <= sreg;
        mosi    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: timeline model plus behavioural SPI slave.
module tb_spi_master;
  localparam int CLK_DIV = 4;
  localparam int HP      = CLK_DIV / 2;

  logic       P_clk = 1'b0, reset = 1'b1;
  logic [7:0] tx_data = '0, rx_data;
  logic       tx_start = 1'b0;
  logic [1:0] ss = '0;
  logic       s0, s1, s2, s3, s_clk, mosi, spic;
  logic       miso = 1'b0, i_mode_set = 1'b0;
  logic [1:0] SPI_MODE = '0;

  spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .P_clk(P_clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .rx_data(rx_data), .ss(ss), .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .s_clk(s_clk), .mosi(mosi), .miso(miso), .i_mode_set(i_mode_set),
    .SPI_MODE(SPI_MODE), .spic(spic)
  );

  always #5 P_clk = ~P_clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Position of the i-th transmitted bit inside a byte.
  function automatic int pos(input int i);
`ifdef SPI_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  // Reference timeline: a transfer accepted at edge T owns the bus for edges T+1..T+37.
  int         cyc = 0, m_t0 = 0;
  bit         m_busy = 0;
  logic [1:0] m_mode = '0, m_mode_prev = '0, m_ss = '0;
  logic [7:0] m_tx = '0, m_slave = '0, m_rx = '0, slave_byte = '0;

  always @(posedge P_clk) begin : mdl
    int d;
    cyc++;
    d = cyc - m_t0;
    m_mode_prev = m_mode;
    if (reset) begin
      m_busy = 0; m_mode = '0; m_mode_prev = '0; m_rx = '0;
    end else begin
      if (m_busy && d == 37) m_rx = m_slave;
      if (m_busy && d >= 38) m_busy = 0;
      if (!m_busy) begin
        if (i_mode_set) m_mode = SPI_MODE;
        if (tx_start) begin
          m_busy = 1; m_t0 = cyc; m_ss = ss; m_tx = tx_data; m_slave = slave_byte;
        end
      end
    end
  end

  // Per-cycle compare plus slave behaviour, sampled away from the active edge.
  int         samp_cnt = 0, shift_cnt = 0, samp_rise = 0, spic_cnt = 0, mosi_age = 0;
  logic [7:0] cap = '0;
  logic [3:0] sel_seen = '0;
  logic       first_bit = 0, prev_sclk = 0, prev_sel_low = 0, last_mosi = 0;

  always @(negedge P_clk) begin : mon
    int d, n, idx;
    logic [3:0] sel_n, exp_sel;
    logic lead, samp;
    sel_n = {s3, s2, s1, s0};
    if (cyc >= 1) begin
      d = cyc - m_t0;
      exp_sel = 4'hF;
      n = 0;
      if (m_busy && d >= 1 && d <= 36) exp_sel[m_ss] = 1'b0;
      if (m_busy && d >= 1) n = (d - 1) / HP;
      if (n > 16) n = 16;
      chk("sel", sel_n, exp_sel);
      chk("s_clk", s_clk, m_mode_prev[1] ^ n[0]);
      chk("spic", spic, m_busy && d == 37);
      chk("rx_data", rx_data, m_rx);
    end
    if (spic) spic_cnt++;
    if (mosi !== last_mosi) mosi_age = 0; else mosi_age++;
    last_mosi = mosi;
    if (sel_n != 4'hF) sel_seen |= ~sel_n;
    if (sel_n != 4'hF && prev_sel_low) begin
      if (s_clk !== prev_sclk) begin
        lead = (s_clk != m_mode[1]);
        samp = (lead == !m_mode[0]);
        if (samp) begin
          if (samp_cnt < 8) begin
            chk("mosi_bit", mosi, m_tx[pos(samp_cnt)]);
            chk("mosi_setup", mosi_age >= HP, 1);
            if (samp_cnt == 0) first_bit = mosi;
            cap[pos(samp_cnt)] = mosi;
            if (s_clk) samp_rise++;
          end
          samp_cnt++;
        end else shift_cnt++;
      end
    end else if (sel_n == 4'hF) begin
      samp_cnt = 0; shift_cnt = 0;
    end
    prev_sel_low = (sel_n != 4'hF);
    prev_sclk = s_clk;
    idx = m_mode[0] ? shift_cnt - 1 : shift_cnt;
    if (idx >= 0 && idx < 8) miso = m_slave[pos(idx)];
  end

  // kind: 1 = mode set to 11 mid-transfer, 2 = second tx_start mid-transfer.
  task automatic xfer(input logic ms, input logic [1:0] md, input logic [1:0] sl,
                      input logic [7:0] tx, input logic [7:0] sb,
                      input int kind, input int at, output int lat);
    @(negedge P_clk);
    slave_byte = sb; i_mode_set = ms; SPI_MODE = md; ss = sl; tx_data = tx; tx_start = 1'b1;
    @(posedge P_clk);
    cap = '0; sel_seen = '0; samp_rise = 0; first_bit = 0;
    lat = 0;
    @(negedge P_clk);
    tx_start = 1'b0; i_mode_set = 1'b0;
    while (!spic && lat < 200) begin
      @(posedge P_clk);
      lat++;
      @(negedge P_clk);
      tx_start = 1'b0; i_mode_set = 1'b0;
      if (lat == at && kind == 1) begin i_mode_set = 1'b1; SPI_MODE = 2'b11; end
      if (lat == at && kind == 2) begin tx_start = 1'b1; tx_data = 8'h55; end
    end
    tx_start = 1'b0; i_mode_set = 1'b0;
  endtask

  initial begin
    int lat, sc0;
    repeat (3) @(posedge P_clk);
    @(negedge P_clk);
    reset = 1'b0;
    chk("rst_sel", {s3, s2, s1, s0}, 4'hF);
    chk("rst_sclk", s_clk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx", rx_data, 8'h00);

    xfer(1'b1, 2'b00, 2'd0, 8'hAA, 8'hBB, 0, 0, lat);
    chk("m0_lat", lat, 37);
    chk("m0_rx", rx_data, 8'hBB);
    chk("m0_mosi", cap, 8'hAA);
    chk("m0_sel", sel_seen, 4'b0001);
    chk("m0_rise", samp_rise, 8);

    xfer(1'b1, 2'b11, 2'd1, 8'h77, 8'h88, 0, 0, lat);
    chk("m3_rx", rx_data, 8'h88);
    chk("m3_sel", sel_seen, 4'b0010);
    chk("m3_rise", samp_rise, 8);
    chk("m3_mosi", cap, 8'h77);
    repeat (3) @(negedge P_clk);
    chk("m3_idle", s_clk, 1);

    xfer(1'b1, 2'b00, 2'd2, 8'h3C, 8'hA5, 1, 10, lat);
    chk("modeign_rx", rx_data, 8'hA5);
    chk("modeign_mosi", cap, 8'h3C);
    repeat (3) @(negedge P_clk);
    chk("modeign_idle", s_clk, 0);

    sc0 = spic_cnt;
    xfer(1'b0, 2'b00, 2'd3, 8'hC3, 8'h5A, 2, 12, lat);
    repeat (5) @(negedge P_clk);
    chk("startign_spic", spic_cnt - sc0, 1);
    chk("startign_mosi", cap, 8'hC3);
    chk("startign_rx", rx_data, 8'h5A);

    // Reset sampled on the edge that would carry the 4th s_clk transition.
    @(negedge P_clk);
    slave_byte = 8'h11; ss = 2'd2; tx_data = 8'hE7; tx_start = 1'b1;
    @(posedge P_clk);
    @(negedge P_clk);
    tx_start = 1'b0;
    repeat (4 * HP) @(negedge P_clk);
    reset = 1'b1;
    @(negedge P_clk);
    reset = 1'b0;
    chk("midrst_sel", {s3, s2, s1, s0}, 4'hF);
    chk("midrst_sclk", s_clk, 0);
    chk("midrst_spic", spic, 0);
    chk("midrst_rx", rx_data, 8'h00);
    xfer(1'b0, 2'b00, 2'd2, 8'h96, 8'h69, 0, 0, lat);
    chk("postrst_lat", lat, 37);
    chk("postrst_rx", rx_data, 8'h69);

`ifdef SPI_LSB_FIRST_EN
    xfer(1'b1, 2'b00, 2'd0, 8'h01, 8'h80, 0, 0, lat);
    chk("lsb_first", first_bit, 1);
    chk("lsb_rx", rx_data, 8'h80);
`endif

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge P_clk);
        i_mode_set = 1'($urandom_range(0, 1));
        SPI_MODE = 2'($urandom_range(0, 3));
      end
      xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(2, 30), lat);
      chk("rand_lat", lat, 37);
    end

    repeat (4) @(negedge P_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
